kernel_stream_arbiter: RTL and testbench
========================================

# kernel_stream_arbiter

Shares one streaming kernel datapath (512-bit ready/avail in, 512-bit ready/avail out, e.g. the per-32-bit-lane increment kernel) between N_CH requester channels. It arbitrates input beats round-robin and records each issued beat's channel in an in-order tag FIFO. Each kernel result is steered back to the channel that issued it. It sits between the host-side stream mux and the kernel instance, and supports zero-latency (combinational) and pipelined in-order kernels.

## Interface
- C_DATA_WIDTH, 512, beat width; must equal the kernel's data width.
- N_CH, 4, number of requester channels, 2..8.
- TAG_DEPTH, 8, maximum beats outstanding inside the kernel; power of 2, ≥2.
- clk  in  1  clock; everything is synchronous to its rising edge.
- reset  in  1  synchronous, active-high reset.
- ch_in_avail  in  N_CH  per-channel input beat valid.
- ch_in_ready  out  N_CH  per-channel input accept.
- ch_in_data  in  N_CH*C_DATA_WIDTH  channel i occupies [i*C_DATA_WIDTH +: C_DATA_WIDTH].
- ch_out_ready  in  N_CH  per-channel result accept.
- ch_out_avail  out  N_CH  per-channel result valid (at most one bit set).
- ch_out_data  out  C_DATA_WIDTH  result data, broadcast to all channels; equals k_out_data.
- k_in_ready  in  1  kernel input accept.
- k_in_avail  out  1  beat offered to the kernel.
- k_in_data  out  C_DATA_WIDTH  data of the granted channel.
- k_out_ready  out  1  result accept to the kernel.
- k_out_avail  in  1  kernel result valid.
- k_out_data  in  C_DATA_WIDTH  kernel result.
- ch_beat_count  out  N_CH*32  per-channel completed-result counters; present only with KERNEL_ARB_STATS_EN.

## Operation
- State:
  - rr pointer (clog2(N_CH) bits).
  - grant lock flag plus locked grant index.
  - Tag FIFO: TAG_DEPTH entries of clog2(N_CH) bits, with rd/wr pointers and an occupancy count (0..TAG_DEPTH).
- Grant:
  - If the lock is set, grant = locked index.
  - Otherwise grant = first i in rr, rr+1, … (mod N_CH) with ch_in_avail[i]; if none, grant = rr.
- Issue:
  - k_in_avail = ch_in_avail[grant] & ~full.
  - k_in_data = ch_in_data[grant].
  - ch_in_ready[i] = (i==grant) & k_in_ready & ~full.
  - accept = k_in_avail & k_in_ready.
- Lock:
  - Set (holding grant) when k_in_avail & ~k_in_ready.
  - Cleared on accept.
  - While locked, grant and k_in_data do not change.
- rr update: on accept, rr <= (grant+1) mod N_CH; otherwise unchanged.
- Return head tag:
  - FIFO non-empty: head = FIFO head entry.
  - FIFO empty: head = grant (bypass, for zero-latency kernels).
- Return path:
  - ch_out_avail[i] = (i==head) & k_out_avail & (~empty | accept).
  - k_out_ready = ch_out_ready[head] & (~empty | accept).
  - ret = k_out_avail & k_out_ready.
- FIFO updates:
  - Push grant on accept, unless empty & ret in the same cycle (bypass: no FIFO change).
  - Pop on ret when non-empty.
  - Push and pop together: occupancy is unchanged.
- Full: accepting is blocked when occupancy == TAG_DEPTH, even if a pop happens in the same cycle.
- Invariant: occupancy equals the number of beats inside the kernel.
- Ordering: the kernel must be in-order and must be reset by the same reset.
- Reset outputs:
  - rr=0, lock=0, FIFO empty.
  - ch_in_ready=0, ch_out_avail=0, k_in_avail=0, k_out_ready=0.
  - Counters=0.
- Reset mid-operation: outstanding tags are discarded. The arbiter drives no handshake in the reset cycle.

## Timing
- Arbiter adds zero cycles. Every path is combinational: ch_in_avail→k_in_avail, k_in_ready→ch_in_ready, k_out_avail→ch_out_avail, ch_out_ready→k_out_ready.
- State (rr, lock, FIFO) updates at the clock edge after the handshake.
- End-to-end latency = kernel latency.
  - Zero-latency kernel: a beat completes in the cycle it is issued.
- Throughput: 1 beat/cycle when the kernel and the destination channel are ready.
- Fairness: with all channels continuously available, channels are served in order 0,1,…,N_CH-1, 0,…
- Channel backpressure:
  - A stalled head channel stalls all returns (head-of-line blocking).
  - Issue continues until the FIFO is full.

## Configuration
- KERNEL_ARB_STATS_EN:
  - Defined: ch_beat_count exists. Counter i increments by 1 on each ret whose head == i, wraps at 2^32, and is cleared by reset.
  - Undefined: the port and counters are absent; all other behaviour is identical.

## Test plan
- Zero-latency +1 kernel, N_CH=4, all channels available with data 0x…05 and all ready → one beat/cycle, grants 0,1,2,3,0; each channel receives 0x…06 (every 32-bit lane +1) in its grant cycle; occupancy stays 0.
- 3-stage pipelined kernel, TAG_DEPTH=8, only channels 1 and 3 available → alternating grants 1,3,1; results are returned to 1,3,1 three cycles after issue.
- k_in_ready held low for 4 cycles while channel 2 is granted and channel 0 asserts → grant stays 2, k_in_data stable; after accept, rr=3 and channel 0 is served next.
- Pipelined kernel with ch_out_ready=0 on the head channel → exactly 8 issues, then all ch_in_ready=0; raising ready drains results in issue order.
- Pulse reset with 5 beats outstanding → the next cycle shows rr=0, FIFO empty, all outputs 0 as specified, counters 0; traffic resumes correctly.
- KERNEL_ARB_STATS_EN defined with 10 beats on ch1 and 3 on ch2 → ch_beat_count shows 10 and 3; preload near 2^32-1 wraps to 0.

Source files
------------

// File: rtl/kernel_stream_arbiter.sv
// kernel_stream_arbiter: shares one in-order streaming kernel between N_CH
// requester channels. Input beats are granted round-robin (the grant is held
// while the kernel stalls) and the channel of every issued beat is queued in
// an in-order tag FIFO, so each kernel result is steered back to its issuer.
// An empty FIFO bypasses the current grant so zero-latency kernels complete a
// beat in its issue cycle. All handshake paths are combinational.
// Optional feature: define KERNEL_ARB_STATS_EN to add the per-channel
// completed-result counters on port ch_beat_count.
module kernel_stream_arbiter #(
   parameter int C_DATA_WIDTH = 512,
   parameter int N_CH         = 4,
   parameter int TAG_DEPTH    = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [N_CH-1:0]              ch_in_avail,
   output logic [N_CH-1:0]              ch_in_ready,
   input  logic [N_CH*C_DATA_WIDTH-1:0] ch_in_data,
   input  logic [N_CH-1:0]              ch_out_ready,
   output logic [N_CH-1:0]              ch_out_avail,
   output logic [C_DATA_WIDTH-1:0]      ch_out_data,
   input  logic                         k_in_ready,
   output logic                         k_in_avail,
   output logic [C_DATA_WIDTH-1:0]      k_in_data,
   output logic                         k_out_ready,
   input  logic                         k_out_avail,
   input  logic [C_DATA_WIDTH-1:0]      k_out_data
`ifdef KERNEL_ARB_STATS_EN
   ,
   output logic [N_CH*32-1:0]           ch_beat_count
`endif
);

   localparam int          CW     = $clog2(N_CH);
   localparam int          PW     = $clog2(TAG_DEPTH);
   localparam int          CNTW   = PW + 1;
   localparam int unsigned NCH_U  = N_CH;

   logic [CW-1:0]   r_rr;
   logic            r_lock;
   logic [CW-1:0]   r_lock_idx;
   logic [CW-1:0]   r_tag [TAG_DEPTH];
   logic [PW-1:0]   r_wr;
   logic [PW-1:0]   r_rd;
   logic [CNTW-1:0] r_cnt;

   logic [CW-1:0]   w_grant;
   logic [CW-1:0]   w_rr_next;
   logic [CW-1:0]   w_head;
   logic            w_empty;
   logic            w_full;
   logic            w_k_in_avail;
   logic            w_accept;
   logic            w_ret_ok;
   logic            w_k_out_ready;
   logic            w_ret;
   logic            w_push;
   logic            w_pop;

   // Grant selection: locked index while stalled, else first available from rr.
   always_comb begin
      int unsigned w_idx;
      logic        w_found;
      w_grant = r_rr;
      w_found = 1'b0;
      w_idx   = 0;
      if (r_lock) begin
         w_grant = r_lock_idx;
      end else begin
         for (int unsigned k = 0; k < NCH_U; k++) begin
            w_idx = (32'(r_rr) + k) % NCH_U;
            if (!w_found && ch_in_avail[w_idx]) begin
               w_grant = CW'(w_idx);
               w_found = 1'b1;
            end
         end
      end
      w_rr_next = (w_grant == CW'(N_CH - 1)) ? '0 : w_grant + 1'b1;
   end

   // Issue and return handshakes; every output is silenced during reset.
   always_comb begin
      w_empty       = (r_cnt == '0);
      w_full        = (r_cnt == CNTW'(TAG_DEPTH));
      w_k_in_avail  = ~reset & ch_in_avail[w_grant] & ~w_full;
      w_accept      = w_k_in_avail & k_in_ready;
      w_head        = w_empty ? w_grant : r_tag[r_rd];
      w_ret_ok      = ~reset & (~w_empty | w_accept);
      w_k_out_ready = ch_out_ready[w_head] & w_ret_ok;
      w_ret         = k_out_avail & w_k_out_ready;
      // An empty FIFO with a same-cycle return is the zero-latency bypass.
      w_push        = w_accept & ~(w_empty & w_ret);
      w_pop         = w_ret & ~w_empty;
      ch_in_ready   = '0;
      ch_out_avail  = '0;
      for (int unsigned i = 0; i < NCH_U; i++) begin
         ch_in_ready[i]  = (w_grant == CW'(i)) & ~reset & k_in_ready & ~w_full;
         ch_out_avail[i] = (w_head == CW'(i)) & k_out_avail & w_ret_ok;
      end
      k_in_avail  = w_k_in_avail;
      k_in_data   = ch_in_data[w_grant*C_DATA_WIDTH +: C_DATA_WIDTH];
      k_out_ready = w_k_out_ready;
      ch_out_data = k_out_data;
   end

   // Round-robin pointer, grant lock and tag FIFO pointers/occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rr       <= '0;
         r_lock     <= 1'b0;
         r_lock_idx <= '0;
         r_wr       <= '0;
         r_rd       <= '0;
         r_cnt      <= '0;
      end else begin
         if (w_accept) begin
            r_rr   <= w_rr_next;
            r_lock <= 1'b0;
         end else if (w_k_in_avail) begin
            r_lock     <= 1'b1;
            r_lock_idx <= w_grant;
         end
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;
         if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
         else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
      end
   end

   // Tag storage: the channel of each beat now inside the kernel.
   always_ff @(posedge clk) begin
      if (w_push) r_tag[r_wr] <= w_grant;
   end

`ifdef KERNEL_ARB_STATS_EN
   logic [31:0] r_beat_cnt [N_CH];

   // Per-channel completed-result counters, wrapping at 2^32.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NCH_U; i++) r_beat_cnt[i] <= '0;
      end else if (w_ret) begin
         r_beat_cnt[w_head] <= r_beat_cnt[w_head] + 32'd1;
      end
   end

   // Flatten counters onto the output port.
   always_comb begin
      ch_beat_count = '0;
      for (int unsigned i = 0; i < NCH_U; i++) ch_beat_count[i*32 +: 32] = r_beat_cnt[i];
   end
`endif

endmodule

// File: tb/tb_kernel_stream_arbiter.sv
// Self-checking bench for kernel_stream_arbiter (N_CH=4, TAG_DEPTH=8, 512-bit).
// A tb kernel model provides a zero-latency or 3-cycle in-order +1-per-lane
// kernel; per-channel source FIFOs feed the inputs; expected results are
// queued by the directed sequence and popped by a separate output monitor.
module tb_kernel_stream_arbiter;

   localparam int W   = 512;
   localparam int NCH = 4;

   typedef struct packed {
      logic [2:0]   ch;
      logic [W-1:0] d;
   } exp_t;

   logic               clk = 1'b0;
   logic               reset;
   logic [NCH-1:0]     ch_in_avail;
   logic [NCH-1:0]     ch_in_ready;
   logic [NCH*W-1:0]   ch_in_data;
   logic [NCH-1:0]     ch_out_ready;
   logic [NCH-1:0]     ch_out_avail;
   logic [W-1:0]       ch_out_data;
   logic               k_in_ready;
   logic               k_in_avail;
   logic [W-1:0]       k_in_data;
   logic               k_out_ready;
   logic               k_out_avail;
   logic [W-1:0]       k_out_data;
`ifdef KERNEL_ARB_STATS_EN
   logic [NCH*32-1:0]  ch_beat_count;
`endif

   int checks = 0;
   int errors = 0;
   exp_t exp_q[$];

   // source FIFOs per channel
   logic [W-1:0] src_d [NCH][16];
   int           src_rd [NCH];
   int           src_wr [NCH];

   // kernel model state
   logic [W-1:0] kq_d [32];
   int           kq_t [32];
   int           kq_rd = 0;
   int           kq_wr = 0;
   int           cyc = 0;
   logic         mode_zl;
   logic         k_stall;

   kernel_stream_arbiter #(.C_DATA_WIDTH(W), .N_CH(NCH), .TAG_DEPTH(8)) dut (
      .clk(clk), .reset(reset),
      .ch_in_avail(ch_in_avail), .ch_in_ready(ch_in_ready), .ch_in_data(ch_in_data),
      .ch_out_ready(ch_out_ready), .ch_out_avail(ch_out_avail), .ch_out_data(ch_out_data),
      .k_in_ready(k_in_ready), .k_in_avail(k_in_avail), .k_in_data(k_in_data),
      .k_out_ready(k_out_ready), .k_out_avail(k_out_avail), .k_out_data(k_out_data)
`ifdef KERNEL_ARB_STATS_EN
      , .ch_beat_count(ch_beat_count)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] lanes(input logic [31:0] v);
      logic [W-1:0] r;
      for (int i = 0; i < W/32; i++) r[i*32 +: 32] = v;
      return r;
   endfunction

   function automatic logic [W-1:0] inc_lanes(input logic [W-1:0] x);
      logic [W-1:0] r;
      for (int i = 0; i < W/32; i++) r[i*32 +: 32] = x[i*32 +: 32] + 32'd1;
      return r;
   endfunction

   function automatic logic [NCH-1:0] oh(input int c);
      logic [NCH-1:0] r;
      r = '0;
      r[c] = 1'b1;
      return r;
   endfunction

   assign k_in_ready  = mode_zl ? !k_stall : (!k_stall && (kq_wr - kq_rd) < 16);
   assign k_out_avail = mode_zl ? k_in_avail : ((kq_wr != kq_rd) && (cyc >= kq_t[kq_rd % 32] + 3));
   assign k_out_data  = mode_zl ? inc_lanes(k_in_data) : kq_d[kq_rd % 32];

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic push_beat(input int c, input logic [31:0] v);
      src_d[c][src_wr[c] % 16] = lanes(v);
      src_wr[c]++;
   endtask

   task automatic push_exp(input int c, input logic [31:0] v);
      exp_t e;
      e.ch = 3'(c);
      e.d  = lanes(v);
      exp_q.push_back(e);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", W'(exp_q.size()), '0);
   endtask

   // Source and kernel model: capture handshakes mid-cycle, update after the edge.
   initial begin
      logic         s_acc, s_ret, s_rst;
      logic [W-1:0] s_kd;
      logic [NCH-1:0] s_take;
      for (int i = 0; i < NCH; i++) begin
         src_rd[i] = 0;
         src_wr[i] = 0;
      end
      ch_in_avail = '0;
      ch_in_data  = '0;
      forever begin
         @(negedge clk);
         s_acc  = k_in_avail & k_in_ready;
         s_kd   = k_in_data;
         s_ret  = k_out_avail & k_out_ready;
         s_take = ch_in_avail & ch_in_ready;
         s_rst  = reset;
         @(posedge clk);
         #1;
         if (s_rst) begin
            kq_rd = kq_wr;
         end else if (!mode_zl) begin
            if (s_ret) kq_rd++;
            if (s_acc) begin
               kq_d[kq_wr % 32] = inc_lanes(s_kd);
               kq_t[kq_wr % 32] = cyc;
               kq_wr++;
            end
         end
         for (int i = 0; i < NCH; i++) begin
            if (s_take[i]) src_rd[i]++;
            ch_in_avail[i] = (src_wr[i] != src_rd[i]);
            ch_in_data[i*W +: W] = src_d[i][src_rd[i] % 16];
         end
         cyc++;
      end
   end

   // Output monitor: every delivered result must match the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && ch_out_avail != '0) begin
            chk("out_onehot", W'($onehot(ch_out_avail)), W'(1));
            for (int i = 0; i < NCH; i++) begin
               if (ch_out_avail[i] && ch_out_ready[i]) begin
                  if (exp_q.size() == 0) begin
                     chk("unexpected_result_ch", W'(i), W'(8));
                  end else begin
                     e = exp_q.pop_front();
                     chk("result_ch", W'(i), W'(e.ch));
                     chk("result_data", ch_out_data, e.d);
                  end
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired actual=running expected=finished");
      $fatal(1);
   end

   initial begin
      int seq1 [5] = '{0, 1, 2, 3, 0};
      int iss;
      reset        = 1'b1;
      mode_zl      = 1'b1;
      k_stall      = 1'b0;
      ch_out_ready = 4'hF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ch_in_ready", W'(ch_in_ready), '0);
      chk("rst_k_in_avail", W'(k_in_avail), '0);
      chk("rst_k_out_ready", W'(k_out_ready), '0);
      chk("rst_ch_out_avail", W'(ch_out_avail), '0);
      @(posedge clk); #2 reset = 1'b0;

      // zero-latency kernel, round robin 0,1,2,3,0 with same-cycle completion
      @(posedge clk);
      push_beat(0, 32'h5); push_beat(0, 32'h5);
      for (int c = 1; c < NCH; c++) push_beat(c, 32'h5);
      for (int k = 0; k < 5; k++) push_exp(seq1[k], 32'h6);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("zl_grant", W'(ch_in_ready), W'(oh(seq1[k])));
         chk("zl_out_avail", W'(ch_out_avail), W'(oh(seq1[k])));
      end
      @(negedge clk);
      chk("zl_idle_ready_rr1", W'(ch_in_ready), W'(4'b0010));
      wait_drain();

      // 3-cycle pipelined kernel, channels 1 and 3
      @(posedge clk); #2 mode_zl = 1'b0;
      @(posedge clk);
      push_beat(1, 32'h10); push_beat(1, 32'h11); push_beat(3, 32'h30);
      push_exp(1, 32'h11); push_exp(3, 32'h31); push_exp(1, 32'h12);
      @(negedge clk); chk("pl_g0", W'(ch_in_ready), W'(4'b0010)); chk("pl_o0", W'(ch_out_avail), '0);
      @(negedge clk); chk("pl_g1", W'(ch_in_ready), W'(4'b1000)); chk("pl_o1", W'(ch_out_avail), '0);
      @(negedge clk); chk("pl_g2", W'(ch_in_ready), W'(4'b0010)); chk("pl_o2", W'(ch_out_avail), '0);
      @(negedge clk); chk("pl_r0", W'(ch_out_avail), W'(4'b0010));
      @(negedge clk); chk("pl_r1", W'(ch_out_avail), W'(4'b1000));
      @(negedge clk); chk("pl_r2", W'(ch_out_avail), W'(4'b0010));
      wait_drain();

      // kernel stall while channel 2 is granted (rr=2), channel 0 also waiting
      @(posedge clk);
      push_beat(2, 32'h20); push_beat(0, 32'h01);
      push_exp(2, 32'h21); push_exp(0, 32'h02);
      #2 k_stall = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("stall_k_in_avail", W'(k_in_avail), W'(1));
         chk("stall_k_in_data", k_in_data, lanes(32'h20));
         chk("stall_ch_in_ready", W'(ch_in_ready), '0);
      end
      @(posedge clk); #2 k_stall = 1'b0;
      @(negedge clk); chk("unstall_grant2", W'(ch_in_ready), W'(4'b0100));
      @(negedge clk); chk("after_rr3_grant0", W'(ch_in_ready), W'(4'b0001));
      wait_drain();

      // head channel blocked: exactly TAG_DEPTH issues, then drain in order
      @(posedge clk);
      for (int k = 0; k < 10; k++) begin
         push_beat(1, 32'h40 + k);
         push_exp(1, 32'h41 + k);
      end
      #2 ch_out_ready = 4'b1101;
      iss = 0;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         if (ch_in_ready[1] && ch_in_avail[1]) iss++;
      end
      chk("full_issue_count", W'(iss), W'(8));
      chk("full_ch_in_ready", W'(ch_in_ready), '0);
      chk("full_head_blocked_avail", W'(ch_out_avail), W'(4'b0010));
      @(posedge clk); #2 ch_out_ready = 4'hF;
      wait_drain();

      // reset with 5 beats outstanding
      @(posedge clk);
      for (int k = 0; k < 5; k++) push_beat(2, 32'h60 + k);
      #2 ch_out_ready = 4'b1011;
      repeat (8) @(negedge clk);
      @(posedge clk); #2 reset = 1'b1;
      @(negedge clk);
      chk("midrst_ch_in_ready", W'(ch_in_ready), '0);
      chk("midrst_k_in_avail", W'(k_in_avail), '0);
      chk("midrst_k_out_ready", W'(k_out_ready), '0);
      chk("midrst_ch_out_avail", W'(ch_out_avail), '0);
      @(posedge clk); #2 begin reset = 1'b0; ch_out_ready = 4'hF; end
      @(negedge clk);
      chk("postrst_ready_rr0", W'(ch_in_ready), W'(4'b0001));
      chk("postrst_k_out_ready", W'(k_out_ready), '0);
      chk("postrst_ch_out_avail", W'(ch_out_avail), '0);
      @(posedge clk);
      push_beat(3, 32'h70);
      push_exp(3, 32'h71);
      @(negedge clk); chk("postrst_grant3", W'(ch_in_ready), W'(4'b1000));
      wait_drain();

`ifdef KERNEL_ARB_STATS_EN
      chk("cnt_ch3_after_rst", W'(ch_beat_count[3*32 +: 32]), W'(1));
      chk("cnt_ch2_after_rst", W'(ch_beat_count[2*32 +: 32]), W'(0));
      @(posedge clk);
      for (int k = 0; k < 10; k++) begin
         push_beat(1, 32'h80 + k);
      end
      for (int k = 0; k < 3; k++) begin
         push_beat(2, 32'h90 + k);
      end
      push_exp(1, 32'h81); push_exp(2, 32'h91);
      push_exp(1, 32'h82); push_exp(2, 32'h92);
      push_exp(1, 32'h83); push_exp(2, 32'h93);
      for (int k = 3; k < 10; k++) push_exp(1, 32'h81 + k);
      wait_drain();
      repeat (4) @(negedge clk);
      chk("cnt_ch1", W'(ch_beat_count[1*32 +: 32]), W'(10));
      chk("cnt_ch2", W'(ch_beat_count[2*32 +: 32]), W'(3));
`endif

      repeat (4) @(negedge clk);
      chk("final_queue_empty", W'(exp_q.size()), '0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
